// File: rtl/trigger_info_readout.sv
// Readout sequencer for the per-L4 trigger info FIFO bank: queues event masks and streams info words lowest L4 first.
// Define TRIGGER_INFO_HEADER_EN to prefix each event with a header word {evt_count[15:8], mask}.
module trigger_info_readout #(
   parameter int INFO_BITS = 32,
   parameter int NUM_L4    = 4,
   parameter int NL4_BITS  = $clog2(NUM_L4),
   parameter int QDEPTH    = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 evt_valid_i,
   input  logic [NUM_L4-1:0]    evt_mask_i,
   output logic [NL4_BITS-1:0]  fifo_addr_o,
   output logic                 fifo_rd_o,
   input  logic [INFO_BITS-1:0] fifo_info_i,
   output logic [INFO_BITS-1:0] data_o,
   output logic                 valid_o,
   output logic                 last_o,
   input  logic                 ready_i,
   output logic                 busy_o,
   output logic                 overflow_o,
   output logic [7:0]           evt_count_o
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] Q_FULL = CNT_W'(QDEPTH);

   typedef enum logic [1:0] {IDLE, HDR, ADDR, OUT} state_t;

   state_t              state;
   logic [NUM_L4-1:0]   wm;
   logic [NUM_L4-1:0]   wm_rest;

   logic [NUM_L4-1:0]   q_mem [QDEPTH];
   logic [PTR_W-1:0]    q_wr;
   logic [PTR_W-1:0]    q_rd;
   logic [CNT_W-1:0]    q_cnt;
   logic [CNT_W-1:0]    q_cnt_nxt;
   logic                q_push;
   logic                q_pop;
   logic [NUM_L4-1:0]   q_head;

   function automatic logic [NL4_BITS-1:0] low_bit(input logic [NUM_L4-1:0] m);
      logic [NL4_BITS-1:0] idx;
      idx = '0;
      for (int i = NUM_L4 - 1; i >= 0; i--) begin
         if (m[i]) idx = NL4_BITS'(i);
      end
      return idx;
   endfunction

`ifdef TRIGGER_INFO_HEADER_EN
   logic [INFO_BITS-1:0] data_r;

   function automatic logic [INFO_BITS-1:0] hdr_word(input logic [7:0] cnt, input logic [NUM_L4-1:0] m);
      logic [INFO_BITS-1:0] w;
      w = '0;
      w[15:8] = cnt;
      w[NUM_L4-1:0] = m;
      return w;
   endfunction

   // In OUT the bank's registered mux output is the data register for the info word.
   assign data_o = (state == OUT) ? fifo_info_i : data_r;
`else
   assign data_o = (state == OUT) ? fifo_info_i : '0;
`endif

   assign fifo_rd_o = (state == OUT) && ready_i;
   assign wm_rest   = wm & (wm - NUM_L4'(1));
   assign q_head    = q_mem[q_rd];
   assign q_pop     = (state == IDLE) && (q_cnt != '0);
   // A push into a full queue still fits when IDLE frees a slot in the same cycle.
   assign q_push    = evt_valid_i && ((q_cnt != Q_FULL) || q_pop);

   always_comb begin
      q_cnt_nxt = q_cnt;
      if (q_push && !q_pop)
         q_cnt_nxt = q_cnt + CNT_W'(1);
      else if (!q_push && q_pop)
         q_cnt_nxt = q_cnt - CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < QDEPTH; i++) q_mem[i] <= '0;
         q_wr       <= '0;
         q_rd       <= '0;
         q_cnt      <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (q_push) begin
            q_mem[q_wr] <= evt_mask_i;
            q_wr        <= q_wr + PTR_W'(1);
         end
         if (q_pop) q_rd <= q_rd + PTR_W'(1);
         q_cnt <= q_cnt_nxt;
         if (evt_valid_i && !q_push) overflow_o <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= IDLE;
         wm          <= '0;
         fifo_addr_o <= '0;
         valid_o     <= 1'b0;
         last_o      <= 1'b0;
         busy_o      <= 1'b0;
         evt_count_o <= '0;
`ifdef TRIGGER_INFO_HEADER_EN
         data_r      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               busy_o <= (q_cnt_nxt != '0);
               if (q_pop) begin
`ifdef TRIGGER_INFO_HEADER_EN
                  wm      <= q_head;
                  state   <= HDR;
                  valid_o <= 1'b1;
                  last_o  <= (q_head == '0);
                  data_r  <= hdr_word(evt_count_o, q_head);
                  busy_o  <= 1'b1;
`else
                  if (q_head != '0) begin
                     wm          <= q_head;
                     fifo_addr_o <= low_bit(q_head);
                     state       <= ADDR;
                     busy_o      <= 1'b1;
                  end else begin
                     evt_count_o <= evt_count_o + 8'd1;
                  end
`endif
               end
            end
`ifdef TRIGGER_INFO_HEADER_EN
            HDR: begin
               if (ready_i) begin
                  valid_o <= 1'b0;
                  last_o  <= 1'b0;
                  if (wm == '0) begin
                     state       <= IDLE;
                     evt_count_o <= evt_count_o + 8'd1;
                     busy_o      <= (q_cnt_nxt != '0);
                  end else begin
                     state       <= ADDR;
                     fifo_addr_o <= low_bit(wm);
                  end
               end
            end
`endif
            ADDR: begin
               state   <= OUT;
               valid_o <= 1'b1;
               last_o  <= (wm_rest == '0);
            end
            OUT: begin
               if (ready_i) begin
                  valid_o <= 1'b0;
                  last_o  <= 1'b0;
                  wm      <= wm_rest;
                  if (wm_rest == '0) begin
                     state       <= IDLE;
                     evt_count_o <= evt_count_o + 8'd1;
                     busy_o      <= (q_cnt_nxt != '0);
                  end else begin
                     state       <= ADDR;
                     fifo_addr_o <= low_bit(wm_rest);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/trigger_info_readout.md
# trigger_info_readout

Readout sequencer for the per-L4 trigger info FIFO bank. It queues the L4 trigger masks of accepted events. For each queued event it walks the set mask bits lowest-index first, steering the bank's address and read-pop strobes. It presents each info word to the event builder on a valid/ready stream, with an optional header word leading each event.

## Interface
Parameters:
- INFO_BITS, 32, width of one info word; must be ≥ 16.
- NUM_L4, 4, number of L4 triggers / FIFOs in the bank; 2..8.
- NL4_BITS, clogb2(NUM_L4-1), address width.
- QDEPTH, 4, depth of the pending-event mask queue; power of two.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- evt_valid_i  in  1  one-cycle strobe: event accepted.
- evt_mask_i  in  NUM_L4  L4 triggers that wrote info for this event.
- fifo_addr_o  out  NL4_BITS  bank FIFO select.
- fifo_rd_o  out  1  pop strobe to the selected FIFO.
- fifo_info_i  in  INFO_BITS  bank output, registered 1 cycle after fifo_addr_o.
- data_o  out  INFO_BITS  readout word.
- valid_o  out  1  data_o valid.
- last_o  out  1  final word of the event.
- ready_i  in  1  downstream accepts when valid_o && ready_i.
- busy_o  out  1  state ≠ IDLE or queue non-empty.
- overflow_o  out  1  sticky: an event was dropped on a full queue.
- evt_count_o  out  8  events fully read out, mod 256.

## Operation
- Queue: a QDEPTH-deep mask FIFO with occupancy counter 0..QDEPTH.
  - Push occurs on evt_valid_i.
  - Pop occurs when IDLE loads an event.
  - Push while full: the mask is dropped and overflow_o is set, unless a pop occurs in the same cycle, in which case the push is accepted.
- FSM states: IDLE, HDR, ADDR, OUT.
- IDLE → HDR if the queue is non-empty and the header is enabled. The head mask is loaded into the working mask `wm`.
- IDLE → ADDR if the queue is non-empty, the header is disabled and the mask is ≠ 0. fifo_addr_o = lowest set bit of the mask.
- IDLE, with the header disabled and mask = 0: pop the queue, increment evt_count_o, stay in IDLE. No output.
- HDR: valid_o=1.
  - data_o = {zeros, evt_count_o[7:0] at [15:8], mask at [NUM_L4-1:0]}.
  - last_o=1 iff mask = 0.
  - On accept: if mask = 0, go to IDLE and count the event; otherwise go to ADDR with fifo_addr_o = lowest set bit.
- ADDR: a single wait cycle that lets the bank's registered mux capture the selected head. Always → OUT.
- OUT: valid_o=1, data_o = fifo_info_i, last_o=1 iff only one bit remains set in `wm`.
  - On accept: fifo_rd_o=1 for this cycle and the current bit of `wm` is cleared.
  - If `wm` is now zero: → IDLE and evt_count_o increments.
  - Otherwise: → ADDR with fifo_addr_o = next lowest set bit.
- fifo_rd_o is high only in OUT on an accept cycle.
- data_o, valid_o and last_o are held stable while valid_o && !ready_i.
- The block assumes a mask bit means that FIFO holds a word. An empty FIFO is not detected.
- Reset (async, any state):
  - FSM returns to IDLE; queue and `wm` are cleared.
  - fifo_addr_o=0, fifo_rd_o=0, valid_o=0, last_o=0, data_o=0.
  - overflow_o=0, evt_count_o=0, busy_o=0.
- Bank FIFOs are reset by their own logic; a mid-event reset abandons the partial event.

## Timing
- fifo_addr_o, valid_o, last_o, data_o, busy_o, overflow_o and evt_count_o are registered. fifo_rd_o = (state==OUT) && ready_i.
- Cycle 0: IDLE sees a non-empty queue.
  - Header enabled: header is valid at cycle 1.
  - Header disabled: fifo_addr_o is valid at cycle 1 (ADDR) and the first info word is valid at cycle 2.
- Each info word takes at least 2 cycles (ADDR + OUT). The pop at the accept edge makes the next head visible by the following OUT.
- An event pushed on cycle n can be loaded by IDLE at cycle n+1 at the earliest.
- evt_count_o updates on the edge after the last word is accepted.

## Configuration
- TRIGGER_INFO_HEADER_EN defined:
  - HDR state is compiled in and each event starts with a header word.
  - A zero-mask event emits a single header word with last_o=1.
- TRIGGER_INFO_HEADER_EN not defined:
  - HDR is removed and events carry only info words.
  - Zero-mask events are consumed and counted with no output.

## Test plan
- NUM_L4=4, no header; mask 4'b1010, FIFO1 holds 0xAAAA0001, FIFO3 holds 0xBBBB0003, ready_i=1.
  - Cycle 1: fifo_addr_o=1. Cycle 2: data_o=0xAAAA0001.
  - Then fifo_addr_o=3, then data_o=0xBBBB0003 with last_o=1.
  - Exactly two fifo_rd_o pulses; evt_count_o=1.
- Header enabled, mask 4'b0001, first event: header word 0x00000001, then the FIFO0 word with last_o=1.
- Header enabled, mask 0: single header 0x00000000 with last_o=1; evt_count_o 0→1.
- Hold ready_i=0 for 5 cycles in OUT: valid_o stays 1, data_o is unchanged and fifo_rd_o=0. On the first ready_i=1, a single fifo_rd_o pulse.
- QDEPTH=4: push 5 events during a stall → overflow_o=1 and 4 events read out. Push while full with a simultaneous IDLE pop → accepted, overflow_o stays 0.
- Assert rst_n_i low mid-event in OUT: all outputs 0 asynchronously and the FSM returns to IDLE. After release, a new event reads out normally.
